// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU write-back scheduler: requester IDs,
// register index width, the write-request record and the scoreboard mask helper.
package fpu_pkg;

    localparam int NREQ    = 3;
    localparam int REQ_ADD = 0;
    localparam int REQ_MUL = 1;
    localparam int REQ_LD  = 2;
    localparam int RIDX_W  = 4;
    localparam int NBUSY   = 32;

    typedef struct packed {
        logic [RIDX_W-1:0] wa;
        logic              a3;
        logic              sod;
        logic [63:0]       wd;
    } wreq_t;

    // Busy bits are indexed {reg, half}; a double covers both halves of reg.
    function automatic logic [NBUSY-1:0] half_mask(input logic [RIDX_W-1:0] ra,
                                                   input logic a,
                                                   input logic sod);
        logic [NBUSY-1:0] m;
        m = '0;
        if (sod) begin
            m[{ra, 1'b0}] = 1'b1;
            m[{ra, 1'b1}] = 1'b1;
        end else begin
            m[{ra, a}] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fpu_wb_fifo.sv
// Per-requester write buffer: registered full/empty, head visible combinationally.
module fpu_wb_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  logic  pop,
    input  wreq_t din,
    output wreq_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    wreq_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic [AW:0]    count_nxt;
    logic           do_push;
    logic           do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Full is registered from the next count, so a pop on a full buffer frees a slot only next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/fpu_wb_sched.sv
// FPU register-file write-back scheduler: three buffered producers, round-robin onto one
// write port, plus a {reg,half} pending-write scoreboard. FPU_WB_PERF_EN enables conflict_cnt.
module fpu_wb_sched
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][RIDX_W-1:0]  req_wa,
    input  logic [NREQ-1:0]              req_a3,
    input  logic [NREQ-1:0]              req_sod,
    input  logic [NREQ-1:0][63:0]        req_wd,
    input  logic                         rsv_valid,
    input  logic [RIDX_W-1:0]            rsv_wa,
    input  logic                         rsv_a3,
    input  logic                         rsv_sod,
    input  logic [1:0][RIDX_W-1:0]       q_ra,
    input  logic [1:0]                   q_a,
    input  logic [1:0]                   q_sod,
    output logic [1:0]                   q_busy,
    output logic                         we3,
    output logic [RIDX_W-1:0]            wa3,
    output logic                         A3,
    output logic                         sod,
    output logic [63:0]                  wd3,
    output logic [15:0]                  conflict_cnt
);

    logic [NREQ-1:0]  full;
    logic [NREQ-1:0]  empty;
    logic [NREQ-1:0]  nonempty;
    logic [NREQ-1:0]  push;
    logic [NREQ-1:0]  pop;
    wreq_t            din  [NREQ];
    wreq_t            head [NREQ];

    logic [1:0]       last_grant;
    logic [1:0]       gnt_idx;
    logic [1:0]       cand;
    logic             gnt;
    wreq_t            sel;
    wreq_t            hold;
    logic [NBUSY-1:0] busy;
    logic [NBUSY-1:0] clr_mask;
    logic [NBUSY-1:0] rsv_mask;

    for (genvar i = 0; i < NREQ; i++) begin : g_buf
        assign din[i]  = '{wa: req_wa[i], a3: req_a3[i], sod: req_sod[i], wd: req_wd[i]};
        assign push[i] = req_valid[i] & ~full[i];

        fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (din[i]),
            .head  (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    assign req_ready = ~full;
    assign nonempty  = ~empty;
    assign gnt       = |nonempty;

    // Scan from farthest to nearest so the first non-empty after last_grant wins.
    always_comb begin
        gnt_idx = last_grant;
        cand    = last_grant;
        for (int k = NREQ; k >= 1; k--) begin
            cand = 2'((int'(last_grant) + k) % NREQ);
            if (nonempty[cand]) begin
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        sel = head[0];
        pop = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == 2'(i)) begin
                sel    = head[i];
                pop[i] = gnt;
            end
        end
    end

    // Buffered writes must never reach the regfile while reset is flushing them.
    assign we3 = gnt & ~reset;
    assign wa3 = gnt ? sel.wa  : hold.wa;
    assign A3  = gnt ? sel.a3  : hold.a3;
    assign sod = gnt ? sel.sod : hold.sod;
    assign wd3 = gnt ? sel.wd  : hold.wd;

    assign clr_mask = gnt ? half_mask(sel.wa, sel.a3, sel.sod) : '0;
    assign rsv_mask = rsv_valid ? half_mask(rsv_wa, rsv_a3, rsv_sod) : '0;

    // Reserve is OR-ed after the clear so a same-edge reserve keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 2'd2;
            hold       <= '0;
            busy       <= '0;
        end else begin
            if (gnt) begin
                last_grant <= gnt_idx;
                hold       <= sel;
            end
            busy <= (busy & ~clr_mask) | rsv_mask;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_query
        assign q_busy[k] = |(busy & half_mask(q_ra[k], q_a[k], q_sod[k]));
    end

`ifdef FPU_WB_PERF_EN
    logic multi;
    assign multi = (nonempty[0] & nonempty[1]) | (nonempty[0] & nonempty[2]) |
                   (nonempty[1] & nonempty[2]);

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (multi && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_fpu_wb_sched.sv
// Directed bench for fpu_wb_sched with a queue-based reference model checked every cycle.
module tb_fpu_wb_sched;
    import fpu_pkg::*;

    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    logic [2:0][3:0]  req_wa;
    logic [2:0]       req_a3;
    logic [2:0]       req_sod;
    logic [2:0][63:0] req_wd;
    logic             rsv_valid;
    logic [3:0]       rsv_wa;
    logic             rsv_a3;
    logic             rsv_sod;
    logic [1:0][3:0]  q_ra;
    logic [1:0]       q_a;
    logic [1:0]       q_sod;
    logic [1:0]       q_busy;
    logic             we3;
    logic [3:0]       wa3;
    logic             A3;
    logic             sod;
    logic [63:0]      wd3;
    logic [15:0]      conflict_cnt;

    int checks   = 0;
    int failures = 0;

    fpu_wb_sched #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wa       (req_wa),
        .req_a3       (req_a3),
        .req_sod      (req_sod),
        .req_wd       (req_wd),
        .rsv_valid    (rsv_valid),
        .rsv_wa       (rsv_wa),
        .rsv_a3       (rsv_a3),
        .rsv_sod      (rsv_sod),
        .q_ra         (q_ra),
        .q_a          (q_a),
        .q_sod        (q_sod),
        .q_busy       (q_busy),
        .we3          (we3),
        .wa3          (wa3),
        .A3           (A3),
        .sod          (sod),
        .wd3          (wd3),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    wreq_t mq [3][$];
    int    m_last;
    bit    m_busy [16][2];
    wreq_t m_hold;
    int    m_conf;
    bit    started = 1'b0;

    function automatic int m_grant();
        for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (mq[c].size() > 0) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            for (int r = 0; r < 16; r++) begin
                m_busy[r][0] = 1'b0;
                m_busy[r][1] = 1'b0;
            end
            m_last  = 2;
            m_hold  = '0;
            m_conf  = 0;
            started = 1'b1;
        end else if (started) begin : upd
            int    g;
            int    ne;
            bit    acc [3];
            wreq_t w;
            g  = m_grant();
            ne = 0;
            for (int i = 0; i < 3; i++) begin
                if (mq[i].size() > 0) ne++;
                acc[i] = req_valid[i] && (mq[i].size() < DEPTH);
            end
            if (ne >= 2 && m_conf < 65535) m_conf++;
            if (g >= 0) begin
                w      = mq[g].pop_front();
                m_last = g;
                m_hold = w;
                if (w.sod) begin
                    m_busy[w.wa][0] = 1'b0;
                    m_busy[w.wa][1] = 1'b0;
                end else begin
                    m_busy[w.wa][w.a3] = 1'b0;
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) mq[i].push_back('{wa: req_wa[i], a3: req_a3[i], sod: req_sod[i], wd: req_wd[i]});
            end
            if (rsv_valid) begin
                if (rsv_sod) begin
                    m_busy[rsv_wa][0] = 1'b1;
                    m_busy[rsv_wa][1] = 1'b1;
                end else begin
                    m_busy[rsv_wa][rsv_a3] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin : cmp
            int    g;
            wreq_t e;
            logic [2:0] rdy;
            logic       qb;
            int         ec;
            g = m_grant();
            chk("cyc_we3", we3, (g >= 0) && !reset);
            if (!reset) begin
                e = (g >= 0) ? mq[g][0] : m_hold;
                chk("cyc_wa3", wa3, e.wa);
                chk("cyc_A3",  A3,  e.a3);
                chk("cyc_sod", sod, e.sod);
                chk("cyc_wd3", wd3, e.wd);
            end
            for (int i = 0; i < 3; i++) rdy[i] = mq[i].size() < DEPTH;
            chk("cyc_ready", req_ready, rdy);
            for (int k = 0; k < 2; k++) begin
                qb = q_sod[k] ? (m_busy[q_ra[k]][0] | m_busy[q_ra[k]][1]) : m_busy[q_ra[k]][q_a[k]];
                chk("cyc_q_busy", q_busy[k], qb);
            end
`ifdef FPU_WB_PERF_EN
            ec = m_conf;
`else
            ec = 0;
`endif
            chk("cyc_conflict", conflict_cnt, ec);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] wa, input logic a, input logic s, input logic [63:0] wd);
        req_valid[i] = 1'b1;
        req_wa[i]    = wa;
        req_a3[i]    = a;
        req_sod[i]   = s;
        req_wd[i]    = wd;
    endtask

    task automatic set_q(input int k, input logic [3:0] ra, input logic a, input logic s);
        q_ra[k]  = ra;
        q_a[k]   = a;
        q_sod[k] = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int   n1;
        logic rdy1;
        int   exp_conf;

        reset     = 1'b1;
        req_valid = '0;
        req_wa    = '0;
        req_a3    = '0;
        req_sod   = '0;
        req_wd    = '0;
        rsv_valid = 1'b0;
        rsv_wa    = '0;
        rsv_a3    = 1'b0;
        rsv_sod   = 1'b0;
        q_ra      = '0;
        q_a       = '0;
        q_sod     = '0;
        step();
        step();
        reset = 1'b0;

        chk("rst_we3",   we3, 1'b0);
        chk("rst_wa3",   wa3, 4'd0);
        chk("rst_wd3",   wd3, 64'd0);
        chk("rst_ready", req_ready, 3'b111);
        chk("rst_busy",  q_busy, 2'b00);
        chk("rst_conf",  conflict_cnt, 16'd0);

        // single double-precision write
        set_req(0, 4'd5, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);
        step();
        req_valid = '0;
        chk("single_we3", we3, 1'b1);
        chk("single_wa3", wa3, 4'd5);
        chk("single_sod", sod, 1'b1);
        chk("single_wd3", wd3, 64'h0123_4567_89AB_CDEF);
        step();
        chk("single_idle_we3", we3, 1'b0);
        chk("single_hold_wa3", wa3, 4'd5);

        // contention straight after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 4'd1, 1'b0, 1'b0, 64'h11);
        set_req(1, 4'd2, 1'b1, 1'b0, 64'h22);
        set_req(2, 4'd3, 1'b0, 1'b1, 64'h33);
        step();
        req_valid = '0;
        chk("rr_grant0", wa3, 4'd1);
        step();
        chk("rr_grant1", wa3, 4'd2);
        step();
        chk("rr_grant2", wa3, 4'd3);
        step();
        chk("rr_idle_we3", we3, 1'b0);
`ifdef FPU_WB_PERF_EN
        exp_conf = 2;
`else
        exp_conf = 0;
`endif
        chk("rr_conflict", conflict_cnt, exp_conf);
        set_req(0, 4'd4, 1'b0, 1'b0, 64'h44);
        set_req(1, 4'd5, 1'b0, 1'b0, 64'h55);
        set_req(2, 4'd6, 1'b0, 1'b0, 64'h66);
        step();
        req_valid = '0;
        chk("rr_round2_first", wa3, 4'd4);
        repeat (3) step();

        // backpressure on requester 1
        n1 = 0;
        for (int c = 0; c < 4; c++) begin
            rdy1 = req_ready[1];
            set_req(0, 4'd8, 1'b0, 1'b1, 64'hA0 + 64'(c));
            set_req(1, 4'd9, 1'b0, 1'b1, 64'hB0 + 64'(n1));
            step();
            if (rdy1) n1++;
            if (c == 1) chk("bp_ready1_drop", req_ready[1], 1'b0);
        end
        req_valid = '0;
        chk("bp_accepts", n1, 3);
        repeat (6) step();

        // scoreboard: single r3 upper
        rsv_valid = 1'b1;
        rsv_wa    = 4'd3;
        rsv_a3    = 1'b1;
        rsv_sod   = 1'b0;
        step();
        rsv_valid = 1'b0;
        set_q(0, 4'd3, 1'b1, 1'b0);
        set_q(1, 4'd3, 1'b0, 1'b1);
        #1;
        chk("sb_r3_upper",  q_busy[0], 1'b1);
        chk("sb_r3_double", q_busy[1], 1'b1);
        set_q(1, 4'd3, 1'b0, 1'b0);
        #1;
        chk("sb_r3_lower", q_busy[1], 1'b0);
        set_req(2, 4'd3, 1'b1, 1'b0, 64'h5555);
        step();
        req_valid = '0;
        chk("sb_write_pending_we3", we3, 1'b1);
        chk("sb_no_bypass", q_busy[0], 1'b1);
        step();
        chk("sb_cleared_upper", q_busy[0], 1'b0);
        chk("sb_cleared_lower", q_busy[1], 1'b0);
        set_q(1, 4'd3, 1'b0, 1'b1);
        #1;
        chk("sb_cleared_double", q_busy[1], 1'b0);

        // same-edge reserve and clear of r7 double
        set_req(0, 4'd7, 1'b0, 1'b1, 64'h77);
        step();
        req_valid = '0;
        rsv_valid = 1'b1;
        rsv_wa    = 4'd7;
        rsv_a3    = 1'b0;
        rsv_sod   = 1'b1;
        step();
        rsv_valid = 1'b0;
        set_q(0, 4'd7, 1'b0, 1'b1);
        #1;
        chk("same_edge_r7", q_busy[0], 1'b1);
        step();
        chk("same_edge_r7_later", q_busy[0], 1'b1);

        // reset with two entries buffered
        set_req(0, 4'd10, 1'b0, 1'b1, 64'hC0);
        set_req(1, 4'd11, 1'b0, 1'b0, 64'hC1);
        step();
        req_valid = '0;
        reset = 1'b1;
        #1;
        chk("rst_mid_we3_gated", we3, 1'b0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rst_mid_idle_we3", we3, 1'b0);
            step();
        end
        set_q(0, 4'd7, 1'b0, 1'b1);
        set_q(1, 4'd3, 1'b1, 1'b0);
        #1;
        chk("rst_mid_busy", q_busy, 2'b00);
        set_q(0, 4'd10, 1'b0, 1'b1);
        set_q(1, 4'd11, 1'b0, 1'b0);
        #1;
        chk("rst_mid_busy2", q_busy, 2'b00);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
